// File: rtl/rom_load_ctrl_if.sv
`timescale 1ns/1ps
// Download-side bus of rom_load_ctrl: ioctl byte stream in, region write port and status out.
// The master drives the ioctl stream; the slave is the load controller.
interface rom_load_ctrl_if;
    logic        I_IOCTL_DOWNLOAD;
    logic        I_IOCTL_WR;
    logic [7:0]  I_IOCTL_INDEX;
    logic [24:0] I_IOCTL_ADDR;
    logic [7:0]  I_IOCTL_DOUT;
    logic [6:0]  O_WR_EN;
    logic [15:0] O_WR_ADDR;
    logic [31:0] O_WR_DATA;
    logic        O_CORE_RESET;
    logic        O_DONE;
    logic        O_ERR;

    modport master (
        output I_IOCTL_DOWNLOAD, I_IOCTL_WR, I_IOCTL_INDEX, I_IOCTL_ADDR, I_IOCTL_DOUT,
        input  O_WR_EN, O_WR_ADDR, O_WR_DATA, O_CORE_RESET, O_DONE, O_ERR
    );

    modport slave (
        input  I_IOCTL_DOWNLOAD, I_IOCTL_WR, I_IOCTL_INDEX, I_IOCTL_ADDR, I_IOCTL_DOUT,
        output O_WR_EN, O_WR_ADDR, O_WR_DATA, O_CORE_RESET, O_DONE, O_ERR
    );
endinterface

// File: rtl/rom_load_ctrl.sv
`timescale 1ns/1ps
// rom_load_ctrl: steers an ioctl ROM download into seven region write ports (dword/word/byte
// packed) and holds the arcade core in reset until a complete, consistent image has arrived.
module rom_load_ctrl #(
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [24:0] IMAGE_BYTES = 25'h076000,
    parameter int          RST_HOLD    = 16
) (
    input  logic           I_CLK_14M,
    input  logic           I_RESET_N,
    rom_load_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

    // Region index 0..6 in write-enable bit order, 7 when outside every region.
    function automatic logic [2:0] region_of(input logic [24:0] a);
        logic [2:0] r;
        if (a < 25'h040000)      r = 3'd0;
        else if (a < 25'h050000) r = 3'd1;
        else if (a < 25'h060000) r = 3'd2;
        else if (a < 25'h068000) r = 3'd3;
        else if (a < 25'h070000) r = 3'd4;
        else if (a < 25'h074000) r = 3'd5;
        else if (a < 25'h076000) r = 3'd6;
        else                     r = 3'd7;
        return r;
    endfunction

    state_t      r_state;
    logic [24:0] r_cnt;
    logic [23:0] r_pack;
    logic [15:0] r_hold_cnt;
    logic        r_armed;
    logic [6:0]  r_wr_en;
    logic [15:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_core_reset;
    logic        r_done;
    logic        r_err;

    logic [24:0] w_addr;
    logic [7:0]  w_dout;
    logic [2:0]  w_region;
    logic        w_match;
    logic        w_start;
    logic        w_accept;
    logic        w_in_image;
    logic        w_complete;
    logic [6:0]  w_hot;
    logic [15:0] w_wr_addr;
    logic [31:0] w_wr_data;

    assign w_addr = bus.I_IOCTL_ADDR;
    assign w_dout = bus.I_IOCTL_DOUT;

    assign bus.O_WR_EN      = r_wr_en;
    assign bus.O_WR_ADDR    = r_wr_addr;
    assign bus.O_WR_DATA    = r_wr_data;
    assign bus.O_CORE_RESET = r_core_reset;
    assign bus.O_DONE       = r_done;
    assign bus.O_ERR        = r_err;

    // Byte acceptance qualifiers and per-region strobe/address/data formation.
    always_comb begin
        w_region   = region_of(w_addr);
        w_match    = (bus.I_IOCTL_INDEX == ROM_INDEX);
        // r_armed demands the window was seen closed first, so a window still open
        // after reset does not restart a load.
        w_start    = bus.I_IOCTL_DOWNLOAD && w_match && r_armed && (r_state != ST_LOAD);
        w_accept   = (r_state == ST_LOAD) && bus.I_IOCTL_DOWNLOAD && bus.I_IOCTL_WR && w_match;
        w_in_image = (w_addr < IMAGE_BYTES);
        w_complete = 1'b0;
        w_hot      = 7'd0;
        w_wr_addr  = 16'd0;
        w_wr_data  = 32'd0;
        case (w_region)
            3'd0: begin
                w_complete = (w_addr[1:0] == 2'b11);
                w_hot      = 7'b000_0001;
                w_wr_addr  = w_addr[17:2];
                w_wr_data  = {r_pack, w_dout};
            end
            3'd1: begin
                w_complete = w_addr[0];
                w_hot      = 7'b000_0010;
                w_wr_addr  = {1'b0, w_addr[15:1]};
                w_wr_data  = {16'h0000, r_pack[7:0], w_dout};
            end
            3'd2: begin
                w_complete = w_addr[0];
                w_hot      = 7'b000_0100;
                w_wr_addr  = {1'b0, w_addr[15:1]};
                w_wr_data  = {16'h0000, r_pack[7:0], w_dout};
            end
            3'd3: begin
                w_complete = w_addr[0];
                w_hot      = 7'b000_1000;
                w_wr_addr  = {2'b00, w_addr[14:1]};
                w_wr_data  = {16'h0000, r_pack[7:0], w_dout};
            end
            3'd4: begin
                w_complete = 1'b1;
                w_hot      = 7'b001_0000;
                w_wr_addr  = {1'b0, w_addr[14:0]};
                w_wr_data  = {24'h000000, w_dout};
            end
            3'd5: begin
                w_complete = 1'b1;
                w_hot      = 7'b010_0000;
                w_wr_addr  = {2'b00, w_addr[13:0]};
                w_wr_data  = {24'h000000, w_dout};
            end
            3'd6: begin
                w_complete = 1'b1;
                w_hot      = 7'b100_0000;
                w_wr_addr  = {3'b000, w_addr[12:0]};
                w_wr_data  = {24'h000000, w_dout};
            end
            default: begin
                w_complete = 1'b0;
                w_hot      = 7'd0;
                w_wr_addr  = 16'd0;
                w_wr_data  = 32'd0;
            end
        endcase
    end

    // Load FSM with registered write port, status flags and core reset.
    always_ff @(posedge I_CLK_14M or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 25'd0;
            r_pack       <= 24'd0;
            r_hold_cnt   <= 16'd0;
            r_armed      <= 1'b0;
            r_wr_en      <= 7'd0;
            r_wr_addr    <= 16'd0;
            r_wr_data    <= 32'd0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_wr_en <= 7'd0;
            if (!bus.I_IOCTL_DOWNLOAD) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end

            if (w_start) begin
                // Entry from IDLE, HOLD or RUN; also wins over HOLD expiry in the same cycle.
                r_state      <= ST_LOAD;
                r_cnt        <= 25'd0;
                r_pack       <= 24'd0;
                r_done       <= 1'b0;
                r_err        <= 1'b0;
                r_armed      <= 1'b0;
                r_core_reset <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_core_reset <= 1'b1;
                    end
                    ST_LOAD: begin
                        if (!bus.I_IOCTL_DOWNLOAD) begin
                            // Any partially packed word is dropped here; the count check catches it.
                            if (r_cnt == IMAGE_BYTES) begin
                                r_state    <= ST_HOLD;
                                r_done     <= 1'b1;
                                r_hold_cnt <= 16'd0;
                            end else begin
                                r_state <= ST_IDLE;
                                r_err   <= 1'b1;
                            end
                        end else if (w_accept) begin
                            r_cnt <= r_cnt + 25'd1;
                            if (w_addr != r_cnt) begin
                                r_err <= 1'b1;
                            end else begin
                                r_err <= r_err;
                            end
                            if (!w_in_image) begin
                                r_err <= 1'b1;
                            end else begin
                                r_pack <= {r_pack[15:0], w_dout};
                                if (w_complete && (w_hot != 7'd0)) begin
                                    r_wr_en   <= w_hot;
                                    r_wr_addr <= w_wr_addr;
                                    r_wr_data <= w_wr_data;
                                end else begin
                                    r_wr_en <= 7'd0;
                                end
                            end
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                    ST_HOLD: begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state      <= ST_RUN;
                            r_core_reset <= 1'b0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 16'd1;
                        end
                    end
                    ST_RUN: begin
                        r_core_reset <= 1'b0;
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_core_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
`timescale 1ns/1ps
// Bench for rom_load_ctrl: a full-size instance for region decoding and a small-image
// instance for completion, hold timing, reset abandonment and restart behaviour.
module tb_rom_load_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        dl_a  = 1'b0;
    logic        dl_b  = 1'b0;
    logic        wr    = 1'b0;
    logic [7:0]  idx   = 8'd0;
    logic [24:0] addr  = 25'd0;
    logic [7:0]  dout  = 8'd0;
    bit          sel   = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          pulses_a = 0;
    int          pulses_b = 0;
    logic [7:0]  mem [logic [24:0]];

    logic [6:0]  o_en;
    logic [15:0] o_addr;
    logic [31:0] o_data;
    logic        o_core_reset, o_done, o_err;

    rom_load_ctrl_if bus_a ();
    rom_load_ctrl_if bus_b ();

    assign bus_a.I_IOCTL_DOWNLOAD = dl_a;
    assign bus_a.I_IOCTL_WR       = wr;
    assign bus_a.I_IOCTL_INDEX    = idx;
    assign bus_a.I_IOCTL_ADDR     = addr;
    assign bus_a.I_IOCTL_DOUT     = dout;
    assign bus_b.I_IOCTL_DOWNLOAD = dl_b;
    assign bus_b.I_IOCTL_WR       = wr;
    assign bus_b.I_IOCTL_INDEX    = idx;
    assign bus_b.I_IOCTL_ADDR     = addr;
    assign bus_b.I_IOCTL_DOUT     = dout;

    rom_load_ctrl dut_a (.I_CLK_14M(clk), .I_RESET_N(rst_n), .bus(bus_a));

    rom_load_ctrl #(.ROM_INDEX(8'd0), .IMAGE_BYTES(25'h001800), .RST_HOLD(16)) dut_b (
        .I_CLK_14M(clk), .I_RESET_N(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    always_comb begin
        if (sel) begin
            o_en = bus_b.O_WR_EN; o_addr = bus_b.O_WR_ADDR; o_data = bus_b.O_WR_DATA;
            o_core_reset = bus_b.O_CORE_RESET; o_done = bus_b.O_DONE; o_err = bus_b.O_ERR;
        end else begin
            o_en = bus_a.O_WR_EN; o_addr = bus_a.O_WR_ADDR; o_data = bus_a.O_WR_DATA;
            o_core_reset = bus_a.O_CORE_RESET; o_done = bus_a.O_DONE; o_err = bus_a.O_ERR;
        end
    end

    always @(negedge clk) begin
        if (bus_a.O_WR_EN != 7'd0) pulses_a++;
        if (bus_b.O_WR_EN != 7'd0) pulses_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a byte that ends its region's unit produces one write of the whole unit,
    // addressed by unit number within the region, earliest byte most significant.
    function automatic void model(input logic [24:0] a, input bit acc, output logic [6:0] en,
                                  output logic [15:0] wa, output logic [31:0] wd);
        int base [7] = '{'h00000, 'h40000, 'h50000, 'h60000, 'h68000, 'h70000, 'h74000};
        int span [7] = '{'h40000, 'h10000, 'h10000, 'h08000, 'h08000, 'h04000, 'h02000};
        int unit [7] = '{4, 2, 2, 2, 1, 1, 1};
        int lim = sel ? 'h1800 : 'h76000;
        int ia  = int'(a);
        en = 7'd0; wa = 16'd0; wd = 32'd0;
        if (acc && ia < lim) begin
            for (int r = 0; r < 7; r++) begin
                if (ia >= base[r] && ia < base[r] + span[r] && (ia - base[r]) % unit[r] == unit[r] - 1) begin
                    en = 7'(1 << r);
                    wa = 16'((ia - base[r]) / unit[r]);
                    for (int k = 0; k < unit[r]; k++)
                        wd = (wd << 8) | 32'(mem[25'(ia - unit[r] + 1 + k)]);
                end
            end
        end
    endfunction

    task automatic send(input logic [24:0] a, input logic [7:0] d, input bit acc, input string tag);
        logic [6:0]  e_en;
        logic [15:0] e_addr;
        logic [31:0] e_data;
        mem[a] = d;
        @(negedge clk);
        addr = a; dout = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        model(a, acc, e_en, e_addr, e_data);
        chk({tag, ".en"}, 32'(o_en), 32'(e_en));
        if (e_en != 7'd0) begin
            chk({tag, ".addr"}, 32'(o_addr), 32'(e_addr));
            chk({tag, ".data"}, o_data, e_data);
        end
    endtask

    task automatic load_image(input int n, input string tag);
        for (int a = 0; a < n; a++) send(25'(a), 8'($urandom()), 1'b1, tag);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (o_done !== 1'b1 && k < 20);
        chk({tag, ".done"}, 32'(o_done), 32'd1);
    endtask

    task automatic chk_status(input string tag, input logic done, input logic err, input logic cr);
        chk({tag, ".done"}, 32'(o_done), 32'(done));
        chk({tag, ".err"}, 32'(o_err), 32'(err));
        chk({tag, ".core_reset"}, 32'(o_core_reset), 32'(cr));
    endtask

    initial begin
        logic [24:0] ra [7];
        int p0, cyc;
        ra = '{25'h050002, 25'h050003, 25'h060004, 25'h060005, 25'h068003, 25'h070010, 25'h074001};

        // Reset values on the full-size instance.
        sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.en", 32'(o_en), 32'd0);
        chk("rst.addr", 32'(o_addr), 32'd0);
        chk("rst.data", o_data, 32'd0);
        chk_status("rst", 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // GP dword packing and contiguous load.
        dl_a = 1'b1;
        repeat (2) @(negedge clk);
        send(25'h0, 8'h11, 1'b1, "gp0");
        send(25'h1, 8'h22, 1'b1, "gp1");
        send(25'h2, 8'h33, 1'b1, "gp2");
        send(25'h3, 8'h44, 1'b1, "gp3");
        chk("gp.const", o_data, 32'h11223344);
        for (int a = 4; a < 16; a++) send(25'(a), 8'($urandom()), 1'b1, "gprnd");
        chk("gp.err", 32'(o_err), 32'd0);

        // Foreign-index strobes mid-load change nothing.
        repeat (2) @(negedge clk);
        p0 = pulses_a;
        idx = 8'd254;
        for (int a = 16; a < 20; a++) send(25'(a), 8'($urandom()), 1'b0, "idx254");
        idx = 8'd0;
        repeat (2) @(negedge clk);
        chk("idx254.pulses", 32'(pulses_a - p0), 32'd0);
        for (int a = 16; a < 20; a++) send(25'(a), 8'($urandom()), 1'b1, "post254");
        chk("post254.err", 32'(o_err), 32'd0);

        // Address jump: still written, error flagged.
        send(25'h040000, 8'hAA, 1'b1, "w7a");
        send(25'h040001, 8'hBB, 1'b1, "w7b");
        chk("w7.const", o_data, 32'h0000AABB);
        chk("jump.err", 32'(o_err), 32'd1);
        for (int i = 0; i < 6; i++) send(ra[i], 8'($urandom()), 1'b1, "regions");
        send(ra[6], 8'h5C, 1'b1, "p6");
        chk("p6.const", o_data, 32'h0000005C);
        send(25'h076000, 8'h77, 1'b1, "beyond");

        // Window closes short of the image.
        dl_a = 1'b0;
        repeat (3) @(negedge clk);
        chk_status("short", 1'b0, 1'b1, 1'b1);

        // Small instance: matching window but foreign index never starts a load.
        sel = 1'b1;
        idx = 8'd254;
        dl_b = 1'b1;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 4; a++) send(25'(a), 8'($urandom()), 1'b0, "idle254");
        dl_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_status("idle254", 1'b0, 1'b0, 1'b1);
        chk("idle254.pulses", 32'(pulses_b), 32'd0);
        idx = 8'd0;

        // Reset asserted while byte 0x1234 is on the bus.
        dl_b = 1'b1;
        repeat (2) @(negedge clk);
        load_image('h1234, "pre_rst");
        @(negedge clk);
        addr = 25'h001234; dout = 8'h5A; wr = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.en", 32'(o_en), 32'd0);
        chk("arst.addr", 32'(o_addr), 32'd0);
        chk("arst.data", o_data, 32'd0);
        chk_status("arst", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        wr = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int a = 'h1234; a < 'h1238; a++) send(25'(a), 8'($urandom()), 1'b0, "after_rst");
        dl_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_status("after_rst", 1'b0, 1'b0, 1'b1);

        // Fresh complete download, then the core-reset hold.
        p0 = pulses_b;
        dl_b = 1'b1;
        repeat (2) @(negedge clk);
        load_image('h1800, "full");
        repeat (2) @(negedge clk);
        chk("full.pulses", 32'(pulses_b - p0), 32'h600);
        dl_b = 1'b0;
        wait_done("full");
        cyc = 0;
        while (o_core_reset === 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("hold.cycles", 32'(cyc), 32'd16);
        chk_status("run", 1'b1, 1'b0, 1'b0);

        // RUN -> LOAD, partial word dropped, byte beyond the image rejected.
        dl_b = 1'b1;
        repeat (2) @(negedge clk);
        chk_status("reload", 1'b0, 1'b0, 1'b1);
        for (int a = 0; a < 6; a++) send(25'(a), 8'($urandom()), 1'b1, "part");
        chk("part.err", 32'(o_err), 32'd0);
        send(25'h001800, 8'h99, 1'b1, "oob");
        chk("oob.err", 32'(o_err), 32'd1);
        dl_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_status("part_close", 1'b0, 1'b1, 1'b1);

        // New download lands on the very cycle the hold expires: load wins.
        dl_b = 1'b1;
        repeat (2) @(negedge clk);
        load_image('h1800, "full2");
        dl_b = 1'b0;
        wait_done("full2");
        repeat (15) @(negedge clk);
        dl_b = 1'b1;
        @(negedge clk);
        chk_status("race", 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("race.core_reset2", 32'(o_core_reset), 32'd1);
        for (int a = 0; a < 4; a++) send(25'(a), 8'($urandom()), 1'b1, "race_ld");
        chk("race_ld.err", 32'(o_err), 32'd0);
        dl_b = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
